// File: rtl/door_plant.sv
// door_plant: behavioural garage-door plant for closed-loop Opener benches.
// Turns the motor commands u/d into a saturating door position, the
// c/o limit switches and a registered obstruction sensor s.
// Optional build macro DOOR_PLANT_INERTIA_EN adds a one-cycle motor
// spin-up whenever motion starts from IDLE or reverses direction.
// u and d are level commands sampled on every rising edge; there is no
// handshake: the plant responds to whatever is present at each edge.
// The FSM state is exported on mstate for monitoring.
module door_plant #(
    parameter int TRAVEL    = 16,
    parameter int POS_W     = 5,
    parameter int START_POS = 8
) (
    input  logic             clk,
    input  logic             r_n,
    input  logic             u,
    input  logic             d,
    input  logic             obs_req,
    output logic             c,
    output logic             o,
    output logic             s,
    output logic [POS_W-1:0] pos,
    output logic             moving,
    output logic             fault,
    output logic [1:0]       mstate
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RISING   = 2'd1,
        LOWERING = 2'd2,
        FAULT    = 2'd3
    } state_t;

    localparam logic [POS_W-1:0] TOP   = POS_W'(TRAVEL);
    localparam logic [POS_W-1:0] START = POS_W'(START_POS);

    state_t           state_q, state_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             moving_q, moving_d;
    logic             s_q;
    logic             run_up, run_dn;

`ifdef DOOR_PLANT_INERTIA_EN
    // Set once the motor has spent its spin-up edge in the current direction.
    logic spun_q, spun_d;

    // Motion is allowed only after a spin-up edge in the same direction.
    always_comb begin
        run_up = (state_q == RISING)   && spun_q;
        run_dn = (state_q == LOWERING) && spun_q;
        spun_d = (state_d == RISING) || (state_d == LOWERING);
    end

    // Spin-up flag register; cleared on reset, IDLE and FAULT.
    always_ff @(posedge clk or negedge r_n) begin
        if (!r_n) spun_q <= 1'b0;
        else      spun_q <= spun_d;
    end
`else
    // Without inertia the door moves on the same edge the command is seen.
    always_comb begin
        run_up = 1'b1;
        run_dn = 1'b1;
    end
`endif

    // Next-state and position update; FAULT is absorbing until reset.
    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        moving_d = 1'b0;
        if (state_q != FAULT) begin
            if (u && d) begin
                state_d = FAULT;
            end else if (u) begin
                state_d = RISING;
                if (run_up && (pos_q < TOP)) begin
                    pos_d    = pos_q + POS_W'(1);
                    moving_d = 1'b1;
                end
            end else if (d) begin
                // An obstruction only blocks downward travel.
                state_d = LOWERING;
                if (run_dn && !s_q && (pos_q != '0)) begin
                    pos_d    = pos_q - POS_W'(1);
                    moving_d = 1'b1;
                end
            end else begin
                state_d = IDLE;
            end
        end
    end

    // State, position and motion registers with asynchronous reset.
    always_ff @(posedge clk or negedge r_n) begin
        if (!r_n) begin
            state_q  <= IDLE;
            pos_q    <= START;
            moving_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            moving_q <= moving_d;
        end
    end

    // Obstruction sensor: obs_req delayed by one flop, independent of state.
    always_ff @(posedge clk or negedge r_n) begin
        if (!r_n) s_q <= 1'b0;
        else      s_q <= obs_req;
    end

    // Limit switches are pure decodes of the position register.
    always_comb begin
        c      = (pos_q == '0);
        o      = (pos_q == TOP);
        s      = s_q;
        pos    = pos_q;
        moving = moving_q;
        fault  = (state_q == FAULT);
        mstate = state_q;
    end

endmodule

// File: tb/tb_door_plant.sv
// tb_door_plant: self-checking bench for door_plant with a behavioural
// door model (integer position, direction and fault flag).
module tb_door_plant;

    localparam int TRAVEL    = 16;
    localparam int POS_W     = 5;
    localparam int START_POS = 8;
    localparam int VW        = POS_W + 7;

    logic             clk = 1'b0;
    logic             r_n = 1'b0;
    logic             u = 1'b0;
    logic             d = 1'b0;
    logic             obs_req = 1'b0;
    logic             c, o, s, moving, fault;
    logic [POS_W-1:0] pos;
    logic [1:0]       mstate;
    logic [VW-1:0]    act_vec;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: door position, direction (0 idle,1 up,2 down,3 fault)
    int m_pos;
    int m_dir;
    bit m_fault;
    bit m_moving;
    bit m_s;
    bit m_spun;

    door_plant #(.TRAVEL(TRAVEL), .POS_W(POS_W), .START_POS(START_POS)) dut (
        .clk(clk), .r_n(r_n), .u(u), .d(d), .obs_req(obs_req),
        .c(c), .o(o), .s(s), .pos(pos), .moving(moving),
        .fault(fault), .mstate(mstate)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    assign act_vec = {c, o, s, moving, fault, mstate, pos};

    function automatic logic [VW-1:0] exp_vec();
        logic [1:0]       dv;
        logic [POS_W-1:0] pv;
        dv = m_dir[1:0];
        pv = m_pos[POS_W-1:0];
        return {(m_pos == 0), (m_pos == TRAVEL), m_s, m_moving, m_fault, dv, pv};
    endfunction

    task automatic model_reset();
        m_pos = START_POS; m_dir = 0; m_fault = 0;
        m_moving = 0; m_s = 0; m_spun = 0;
    endtask

    task automatic model_edge();
        bit s_old;
        int want;
        if (!r_n) begin model_reset(); return; end
        s_old = m_s;
        m_s = obs_req;
        m_moving = 0;
        if (m_fault) return;
        if (u && d) begin m_fault = 1; m_dir = 3; m_spun = 0; return; end
        if (!u && !d) begin m_dir = 0; m_spun = 0; return; end
        want = u ? 1 : 2;
`ifdef DOOR_PLANT_INERTIA_EN
        if (m_dir != want || !m_spun) begin m_dir = want; m_spun = 1; return; end
`endif
        m_dir = want;
        if (want == 1 && m_pos < TRAVEL) begin m_pos++; m_moving = 1; end
        else if (want == 2 && !s_old && m_pos > 0) begin m_pos--; m_moving = 1; end
    endtask

    // driver: one clock edge, model follows, outputs settle 1 ns later
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // driver: move the door to a target position with a cycle budget
    task automatic drive_to(input int target);
        int budget;
        budget = 60;
        obs_req = 0;
        u = (target > m_pos);
        d = (target < m_pos);
        while (m_pos != target && budget > 0) begin
            step();
            budget--;
        end
        u = 0; d = 0;
        n_checks++;
        if (pos !== POS_W'(target)) begin
            n_fail++;
            $display("FAIL drive_to got=%0d exp=%0d", pos, target);
        end
    endtask

    task automatic test_reset();
        r_n = 0; u = 0; d = 0; obs_req = 0;
        model_reset();
        repeat (2) begin
            step();
            n_checks++;
            if (act_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL reset_hold got=%h exp=%h", act_vec, exp_vec());
            end
        end
        r_n = 1;
        repeat (5) begin
            step();
            n_checks++;
            if (act_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL reset_idle got=%h exp=%h", act_vec, exp_vec());
            end
        end
        n_checks++;
        if (pos !== 5'd8 || c !== 1'b0 || o !== 1'b0 || s !== 1'b0 ||
            mstate !== 2'd0 || fault !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values got pos=%0d c=%b o=%b s=%b st=%0d f=%b exp pos=8 rest 0",
                     pos, c, o, s, mstate, fault);
        end
    endtask

    task automatic test_full_open();
        u = 1; d = 0;
        repeat (12) begin
            step();
            n_checks++;
            if (act_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL open t=%0t got=%h exp=%h", $time, act_vec, exp_vec());
            end
        end
        n_checks++;
        if (pos !== 5'd16 || o !== 1'b1 || c !== 1'b0 || moving !== 1'b0) begin
            n_fail++;
            $display("FAIL open_limit got pos=%0d o=%b c=%b mv=%b exp 16 1 0 0", pos, o, c, moving);
        end
    endtask

    task automatic test_full_close();
        u = 0; d = 1;
        repeat (20) begin
            step();
            n_checks++;
            if (act_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL close t=%0t got=%h exp=%h", $time, act_vec, exp_vec());
            end
        end
        d = 0;
        n_checks++;
        if (pos !== 5'd0 || c !== 1'b1 || o !== 1'b0) begin
            n_fail++;
            $display("FAIL close_limit got pos=%0d c=%b o=%b exp 0 1 0", pos, c, o);
        end
    endtask

    task automatic test_obstruction();
        drive_to(10);
        d = 1; obs_req = 1;
        step();
        n_checks++;
        if (act_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL obs_first got=%h exp=%h", act_vec, exp_vec());
        end
`ifndef DOOR_PLANT_INERTIA_EN
        n_checks++;
        if (pos !== 5'd9 || s !== 1'b1) begin
            n_fail++;
            $display("FAIL obs_edge got pos=%0d s=%b exp pos=9 s=1", pos, s);
        end
`endif
        repeat (4) begin
            step();
            n_checks++;
            if (act_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL obs_blocked got=%h exp=%h", act_vec, exp_vec());
            end
        end
        n_checks++;
        if (moving !== 1'b0 || mstate !== 2'd2) begin
            n_fail++;
            $display("FAIL obs_hold got mv=%b st=%0d exp mv=0 st=2", moving, mstate);
        end
        obs_req = 0;
        repeat (3) begin
            step();
            n_checks++;
            if (act_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL obs_clear got=%h exp=%h", act_vec, exp_vec());
            end
        end
        d = 0; u = 1; obs_req = 1;
        repeat (4) begin
            step();
            n_checks++;
            if (act_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL obs_up got=%h exp=%h", act_vec, exp_vec());
            end
        end
        u = 0; obs_req = 0;
        step();
    endtask

    task automatic test_fault();
        drive_to(5);
        u = 1; d = 1;
        step();
        n_checks++;
        if (act_vec !== exp_vec() || fault !== 1'b1 || pos !== 5'd5 || mstate !== 2'd3) begin
            n_fail++;
            $display("FAIL fault_entry got=%h exp=%h", act_vec, exp_vec());
        end
        d = 0;
        repeat (5) begin
            step();
            n_checks++;
            if (act_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL fault_hold got=%h exp=%h", act_vec, exp_vec());
            end
        end
        #2 r_n = 0;
        model_reset();
        #1;
        n_checks++;
        if (act_vec !== exp_vec() || pos !== 5'd8 || fault !== 1'b0 || mstate !== 2'd0) begin
            n_fail++;
            $display("FAIL async_reset got=%h exp=%h", act_vec, exp_vec());
        end
        u = 0;
        #1 r_n = 1;
        step();
        n_checks++;
        if (act_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL after_reset got=%h exp=%h", act_vec, exp_vec());
        end
    endtask

    task automatic test_random();
        int r;
        int n;
        for (int it = 0; it < 60; it++) begin
            r = $urandom_range(0, 19);
            u = (r == 0) || (r >= 1 && r <= 7);
            d = (r == 0) || (r >= 8 && r <= 14);
            obs_req = ($urandom_range(0, 3) == 0);
            n = $urandom_range(1, 6);
            repeat (n) begin
                step();
                n_checks++;
                if (act_vec !== exp_vec()) begin
                    n_fail++;
                    $display("FAIL random it=%0d got=%h exp=%h", it, act_vec, exp_vec());
                end
            end
            if (m_fault) begin
                #2 r_n = 0;
                model_reset();
                #1;
                n_checks++;
                if (act_vec !== exp_vec()) begin
                    n_fail++;
                    $display("FAIL random_reset got=%h exp=%h", act_vec, exp_vec());
                end
                #1 r_n = 1;
            end
        end
        u = 0; d = 0; obs_req = 0;
        step();
    endtask

`ifdef DOOR_PLANT_INERTIA_EN
    task automatic test_inertia();
        logic [POS_W-1:0] exp_p[$];
        #2 r_n = 0;
        model_reset();
        #2 r_n = 1;
        exp_p = '{5'd8, 5'd9, 5'd10, 5'd10, 5'd9};
        for (int i = 0; i < 5; i++) begin
            u = (i < 3);
            d = (i >= 3);
            step();
            n_checks++;
            if (pos !== exp_p[i] || act_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL inertia i=%0d got pos=%0d exp pos=%0d", i, pos, exp_p[i]);
            end
        end
        u = 0; d = 0;
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_full_open();
        test_full_close();
        test_obstruction();
        test_fault();
        test_random();
`ifdef DOOR_PLANT_INERTIA_EN
        test_inertia();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/door_plant.md
Name: door_plant

Overview:
- Behavioural plant model for the garage-door Opener.
- Consumes the Opener motor commands `u`/`d` and produces the limit switches `c`/`o` and the obstruction sensor `s` that the Opener reads.
- Tracks door position with a saturating counter and a small motion FSM.
- Used in closed-loop benches and FPGA demos so the Opener can run without real hardware.

Parameters:
- TRAVEL, 16: clock cycles for full travel, closed (pos=0) to open (pos=TRAVEL); legal range 2..2^POS_W-1.
- POS_W, 5: width of the position counter and the `pos` output.
- START_POS, 8: position loaded on reset (mid-travel by default); legal range 0..TRAVEL.

Ports:
- clk  in  1  system clock, rising edge.
- r_n  in  1  reset, asynchronous assert, active-low; release synchronous to clk.
- u  in  1  motor up command from Opener.
- d  in  1  motor down command from Opener.
- obs_req  in  1  bench/switch-injected obstacle present in the door path.
- c  out  1  closed limit switch (pos==0).
- o  out  1  open limit switch (pos==TRAVEL).
- s  out  1  obstruction sensor.
- pos  out  POS_W  current door position.
- moving  out  1  door moved on the last edge.
- fault  out  1  sticky motor fault: `u` and `d` asserted together.
- mstate  out  2  plant state: IDLE=0, RISING=1, LOWERING=2, FAULT=3.

Behaviour:
- Reset (r_n=0, asynchronous):
  - pos=START_POS, mstate=IDLE, moving=0, fault=0, s=0.
  - c=(START_POS==0); o=(START_POS==TRAVEL).
  - Reset mid-motion aborts the motion immediately; no residual movement after release.
- `c`, `o` and `pos` decode: `c` and `o` are pure decodes of the `pos` register, so they change on the same edge as `pos`. No extra latency.
- `s` is `obs_req` registered by one flop: 1-cycle latency, and `s` is independent of state.
- FSM, evaluated every rising edge when fault=0, with priority top to bottom:
  1. u&d → FAULT. Set fault=1; pos holds; moving=0.
  2. u&!d → RISING.
     - If pos<TRAVEL: pos+1, moving=1.
     - Else (o=1): pos holds, moving=0. Driving into the limit saturates and is never an error.
  3. d&!u → LOWERING.
     - If s=1: pos holds, moving=0 (door blocked); mstate stays LOWERING.
     - Else if pos>0: pos-1, moving=1.
     - Else: hold, moving=0.
  4. !u&!d → IDLE. pos holds; moving=0.
- FAULT state:
  - Absorbing until r_n asserts.
  - pos frozen; moving=0.
  - u/d ignored.
  - c/o keep decoding the frozen pos.
- Obstruction:
  - Only blocks downward motion.
  - Upward motion proceeds with s=1 (the Opener reverses on s).
- Arithmetic: pos never wraps. Increment is gated at TRAVEL and decrement at 0. All compares are unsigned POS_W-bit.
- Direction change (RISING↔LOWERING on consecutive edges): takes effect on that edge with no dead time, unless the optional feature is enabled.
- c and o are never both 1 (TRAVEL≥1).

Optional Feature:
- Macro: DOOR_PLANT_INERTIA_EN.
- Defined:
  - Any transition from IDLE, or any reversal between RISING and LOWERING, first spends one spin-up cycle in the new mstate with pos held and moving=0.
  - Counting starts on the following edge.
  - A 1-bit spin-up flag, cleared on reset and on entry to FAULT, implements this.
  - Full travel from a limit takes TRAVEL+1 cycles.
- Undefined: motion begins on the same edge the command is sampled. No spin-up flag is synthesised.

Test Plan:
1. Reset hold-off: r_n=0 for 2 cycles, then release with u=d=0 → pos=8, c=0, o=0, s=0, mstate=IDLE, fault=0, stable for 5 cycles.
2. Full open: from pos=8, u=1 for 12 cycles →
   - pos=9..16, moving=1 for 8 cycles;
   - o=1 on the edge pos reaches 16;
   - pos stays 16 and moving=0 for the remaining 4 cycles;
   - c=0 throughout.
3. Full close: from pos=16, d=1 for 20 cycles → pos reaches 0 after 16 edges; c=1 on that edge; pos holds at 0 and never wraps to 31.
4. Obstruction: from pos=10, d=1 and obs_req=1 asserted at edge N →
   - s=1 after edge N;
   - pos=9 after edge N (s was 0 when sampled), then holds 9 with moving=0.
   - Drop obs_req: s=0 one edge later, then pos decrements again.
   - Repeat with u=1 and obs_req=1 → pos increments despite s=1.
5. Fault and mid-operation reset: from pos=5, u=d=1 for one cycle → mstate=FAULT, fault=1, pos=5. Then u=1 for 5 cycles → pos stays 5. Pulse r_n low mid-cycle → async clear: fault=0, pos=8, mstate=IDLE without waiting for an edge.
6. With DOOR_PLANT_INERTIA_EN: from pos=8 IDLE, u=1 → pos holds 8 for the first edge, then 9, 10 on the next two. Switch to d=1 → one held edge at 10, then 9.
